// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, A, B (shift amount in B[SW-1:0]), op;
//        out_valid/out_ready, res. Latency STAGES cycles; the whole pipe stalls when res is not taken.
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
);
  localparam int SW   = $clog2(WIDTH);
  localparam int BASE = SW / STAGES;
  localparam int REM  = SW % STAGES;
  logic adv;
  function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] d, input logic [1:0] o,
                                           input logic g, input int l);
    logic [2*WIDTH-1:0] w;
    w = (o == 2'd3 ? {d, d} : o == 2'd2 ? {{WIDTH{g}}, d} : {{WIDTH{1'b0}}, d}) >> (1 << l);
    return o == 2'd0 ? d << (1 << l) : w[WIDTH-1:0];
  endfunction
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  for (genvar s = 0; s < STAGES; s++) begin : g
    // Earlier stages take the extra mux level when SW does not divide evenly.
    localparam int LO = s * BASE + (s < REM ? s : REM);
    localparam int HI = LO + BASE + (s < REM ? 1 : 0);
    logic [WIDTH-1:0] di, dn, dq;
    logic [SW-1:0]    si, sq;
    logic [1:0]       oi, oq;
    logic             gi, gq, vi, vq;
    if (s == 0) begin : h
      assign di = A;
      assign si = B[SW-1:0];
      assign oi = op;
      assign gi = A[WIDTH-1];
      assign vi = in_valid;
    end else begin : h
      assign di = g[s-1].dq;
      assign si = g[s-1].sq;
      assign oi = g[s-1].oq;
      assign gi = g[s-1].gq;
      assign vi = g[s-1].vq;
    end
    // gi is the sign of the original A, so SRA fill never depends on partially shifted data.
    always_comb begin
      dn = di;
      for (int l = LO; l < HI; l++) dn = si[l] ? lvl(dn, oi, gi, l) : dn;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        dq <= '0;
        sq <= '0;
        oq <= '0;
        gq <= 1'b0;
        vq <= 1'b0;
      end else if (adv) begin
        dq <= dn;
        sq <= si;
        oq <= oi;
        gq <= gi;
        vq <= vi;
      end
  end
  assign res       = g[STAGES-1].dq;
  assign out_valid = g[STAGES-1].vq;
endmodule
